seg_scan_display: RTL
=====================

# seg_scan_display

Parametrised, time-multiplexed seven-segment display scanner. The CPU top level drives its 8-bit `Dis` output through this block, which replaces the single fixed digit output with DIGITS scanned hex digits. It also adds decimal-point control, optional leading-zero blanking, and tear-free frame-synchronous updates. It sits between the CPU's output register and the board's segment and anode pins.

## Interface
- `DIGITS`, default 4: number of scanned digits, legal range 1..8.
- `DIV`, default 50000: clock cycles each digit is driven, legal range ≥1.
- `ACTIVE_LOW`, default 1: 1 means `Dis` and `An` are active-low; 0 means active-high.
- `CLK`, input, 1: single clock. All logic is on the rising edge.
- `RST`, input, 1: reset, synchronous, active-high.
- `load`, input, 1: capture `data`, `dp_mask` and `lzb` into the pending register.
- `data`, input, 4*DIGITS: hex nibbles. Nibble i is `data[4i+3:4i]`; digit 0 is rightmost.
- `dp_mask`, input, DIGITS: bit i lights the decimal point of digit i.
- `lzb`, input, 1: leading-zero blanking enable.
- `Dis`, output, 8: `{dp,g,f,e,d,c,b,a}`, registered.
- `An`, output, DIGITS: one-hot digit enable, registered.
- `frame_done`, output, 1: one-cycle pulse at each frame boundary.

## Operation
- Prescaler `cnt` counts 0..DIV-1 and wraps. `tick` = (`cnt`==DIV-1).
- Digit index `idx` advances on `tick` and wraps from DIGITS-1 to 0.
- Frame boundary = `tick` while `idx`==DIGITS-1.
- Registers:
  - pending register: data, dp, lzb, plus a `pend` flag.
  - display register: the committed value that is actually shown.
- `load`: the pending register takes the inputs and `pend` is set to 1. Back-to-back loads: the last one wins.
- Frame boundary with `pend`=1: pending is copied into display and `pend` is cleared.
- Simultaneous `load` and frame boundary: the incoming inputs are committed directly to display, and `pend` ends at 0.
- The display register never changes mid-frame, so there is no tearing.
- Decode (active-high form, g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Blanking, when committed lzb=1:
  - digit i (i>0) is blanked if nibble i and every higher nibble are 0.
  - digit 0 is never blanked.
  - a blanked digit has segments g..a off; dp still follows the dp mask.
- Polarity: with ACTIVE_LOW=1, `Dis` and `An` are the bitwise inverse of the active-high form.

## Timing
- Reset (`RST`=1 at an edge):
  - `cnt`=0, `idx`=0, `pend`=0.
  - pending and display registers all zero, lzb=0.
  - `Dis` = all segments off (8'hFF when ACTIVE_LOW=1).
  - `An` = all digits off.
  - `frame_done`=0.
- Reset asserted mid-frame or mid-pending discards all state, including any uncommitted load.
- Output latency: `Dis`/`An` register the decode of the current `idx` and display register, so they lag `idx` by one cycle.
  - First edge after reset release: digit 0 is driven.
  - Each digit is driven for exactly DIV consecutive cycles.
  - Frame period = DIGITS×DIV cycles.
- `frame_done` is registered. It is high for the one cycle after every frame-boundary edge, whether or not a commit happened.
- Load-to-display latency: the data appears on digit 0 on the cycle after the next frame boundary. Worst case is DIGITS×DIV+1 cycles.
- DIV=1: `idx` advances every cycle, and every cycle of the last digit is a frame boundary.
- DIGITS=1: every `tick` is a frame boundary.

## Test plan
Common setup: DIGITS=4, DIV=4, ACTIVE_LOW=1.
- Reset behaviour: hold `RST` 3 cycles, then release.
  - During reset: `Dis`=FF, `An`=F.
  - First cycle after release: `An`=E, `Dis`=C0 ("0").
  - `An` then follows E,D,B,7, holding each for 4 cycles.
  - `frame_done` pulses every 16 cycles.
- Frame-synchronous commit: `load` data=16'h12AF, dp_mask=0, at mid-frame (`idx`=1).
  - Shown digits stay "0" until the frame boundary.
  - Next frame shows digit 0 = 8E (F), digit 1 = 88 (A), digit 2 = A4 (2), digit 3 = F9 (1).
- Leading-zero blanking: `load` data=16'h0050, lzb=1, dp_mask=4'b0100.
  - Digit 3 `Dis` = FF (blanked).
  - Digit 2 `Dis` = 7F (segments blanked, dp lit).
  - Digit 1 `Dis` = 92 (5).
  - Digit 0 `Dis` = C0 (0, never blanked).
- Load collisions:
  - Two loads in the same frame (1111 then 2222): only 2222 is displayed.
  - `load` 3333 on the exact frame-boundary cycle: committed immediately, `pend`=0 afterwards.
- Reset with pending load: assert `RST` with a load pending.
  - After release, digits show 0 and no stale commit occurs at the next boundary.
- Edge parameters: DIV=1, DIGITS=1, ACTIVE_LOW=0.
  - `An`=1 constantly.
  - `frame_done` is high every cycle.
  - A load of 8 appears as `Dis`=7F two cycles later.

Source files
------------

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment scanner with decimal points, leading-zero blanking
// and frame-synchronous (tear-free) commit of newly loaded values.
module seg_scan_display #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  lzb,
  output logic [7:0]            Dis,
  output logic [DIGITS-1:0]     An,
  output logic                  frame_done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DW = 4 * DIGITS;
  localparam logic        POL = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic              r_pend;
  logic [DW-1:0]     r_pend_data;
  logic [DIGITS-1:0] r_pend_dp;
  logic              r_pend_lzb;
  logic [DW-1:0]     r_disp_data;
  logic [DIGITS-1:0] r_disp_dp;
  logic              r_disp_lzb;
  logic [7:0]        r_dis;
  logic [DIGITS-1:0] r_an;
  logic              r_frame_done;

  logic              w_tick;
  logic              w_frame;
  logic [3:0]        w_nib;
  logic              w_dp;
  logic              w_upper_nz;
  logic              w_blank;
  logic [6:0]        w_seg;
  logic [DIGITS-1:0] w_an_hi;
  logic [7:0]        w_dis_c;
  logic [DIGITS-1:0] w_an_c;

  assign w_tick  = (r_cnt == CNT_LAST);
  assign w_frame = w_tick && (r_idx == IDX_LAST);

  // Prescaler and digit index
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Pending register takes loads; display register only changes on a frame boundary
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_lzb  <= 1'b0;
      r_disp_data <= '0;
      r_disp_dp   <= '0;
      r_disp_lzb  <= 1'b0;
    end else if (load && w_frame) begin
      r_pend      <= 1'b0;
      r_pend_data <= data;
      r_pend_dp   <= dp_mask;
      r_pend_lzb  <= lzb;
      r_disp_data <= data;
      r_disp_dp   <= dp_mask;
      r_disp_lzb  <= lzb;
    end else if (load) begin
      r_pend      <= 1'b1;
      r_pend_data <= data;
      r_pend_dp   <= dp_mask;
      r_pend_lzb  <= lzb;
    end else if (w_frame && r_pend) begin
      r_pend      <= 1'b0;
      r_disp_data <= r_pend_data;
      r_disp_dp   <= r_pend_dp;
      r_disp_lzb  <= r_pend_lzb;
    end
  end

  // Select the current digit and decide whether it is a leading zero
  always_comb begin
    w_nib      = 4'h0;
    w_dp       = 1'b0;
    w_upper_nz = 1'b0;
    w_an_hi    = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_idx == IW'(i)) begin
        w_nib      = r_disp_data[4*i +: 4];
        w_dp       = r_disp_dp[i];
        w_an_hi[i] = 1'b1;
      end
      if ((IW'(i) >= r_idx) && (r_disp_data[4*i +: 4] != 4'h0)) begin
        w_upper_nz = 1'b1;
      end
    end
    w_blank = r_disp_lzb && (r_idx != '0) && !w_upper_nz;
  end

  always_comb begin
    w_seg = 7'h00;
    case (w_nib)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      4'hF: w_seg = 7'h71;
      default: w_seg = 7'h00;
    endcase
  end

  assign w_dis_c = {w_dp, (w_blank ? 7'h00 : w_seg)} ^ {8{POL}};
  assign w_an_c  = w_an_hi ^ {DIGITS{POL}};

  // Pin registers; reset drives every segment and anode inactive
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dis        <= {8{POL}};
      r_an         <= {DIGITS{POL}};
      r_frame_done <= 1'b0;
    end else begin
      r_dis        <= w_dis_c;
      r_an         <= w_an_c;
      r_frame_done <= w_frame;
    end
  end

  assign Dis        = r_dis;
  assign An         = r_an;
  assign frame_done = r_frame_done;

endmodule
